// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the MainMem port arbiter: FSM states, requester IDs, memory op codes.
package proc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } mem_op_t;

  localparam int WAIT_W = 8;

  function automatic req_id_t other_req(input req_id_t id);
    return (id == REQ_I) ? REQ_D : REQ_I;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// MainMem port bundle: the arbiter is master (drives OE/WE/Addr/Data), memory is slave.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner select between I and D requesters.
// MEM_ARB_RR_EN: ties resolved by the round-robin pointer; otherwise D always beats I.
module mem_arb_pick
  import proc_pkg::*;
(
  input  logic    i_req,
  input  logic    d_req,
`ifdef MEM_ARB_RR_EN
  input  req_id_t rr_ptr,
`endif
  output logic    grant_any,
  output req_id_t winner
);

  always_comb begin
    grant_any = i_req | d_req;
    winner    = REQ_I;
`ifdef MEM_ARB_RR_EN
    if (i_req && d_req) winner = rr_ptr;
    else if (d_req)     winner = REQ_D;
`else
    if (d_req) winner = REQ_D;
`endif
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single MainMem port between instruction fetch (I) and Cache2 (D), one transaction at a time.
// Optional round-robin arbitration with `define MEM_ARB_RR_EN (default: fixed D-over-I priority).
module mem_port_arbiter
  import proc_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_rd,
  input  logic [ADDR_W-1:0]  i_addr,
  output logic               i_ack,
  output logic [DATA_W-1:0]  i_rdata,
  input  logic               d_rd,
  input  logic               d_wr,
  input  logic [ADDR_W-1:0]  d_addr,
  input  logic [DATA_W-1:0]  d_wdata,
  output logic               d_ack,
  output logic [DATA_W-1:0]  d_rdata,
  mem_port_arbiter_if.master mem,
  output logic               abort
);

  function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  arb_state_t        state, state_nxt;
  req_id_t           win_q;
  mem_op_t           op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic [WAIT_W-1:0] wait_q;
  logic              aborted_q;

  logic    grant_any;
  req_id_t winner;
  logic    timeout;

`ifdef MEM_ARB_RR_EN
  req_id_t rr_ptr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                         rr_ptr_q <= REQ_I;
    else if (state == IDLE && grant_any) rr_ptr_q <= other_req(winner);
  end

  mem_arb_pick u_pick (
    .i_req     (i_rd),
    .d_req     (d_rd | d_wr),
    .rr_ptr    (rr_ptr_q),
    .grant_any (grant_any),
    .winner    (winner)
  );
`else
  mem_arb_pick u_pick (
    .i_req     (i_rd),
    .d_req     (d_rd | d_wr),
    .grant_any (grant_any),
    .winner    (winner)
  );
`endif

  // Abort fires on the BUSY edge where the wait count would reach MAX_WAIT.
  assign timeout = (MAX_WAIT != 0) && ((int'(wait_q) + 1) == MAX_WAIT);

  // Stage boundary: FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = BUSY;
      BUSY:    if (mem.mem_ready || timeout) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem.mem_read  = 1'b0;
    mem.mem_write = 1'b0;
    i_ack         = 1'b0;
    d_ack         = 1'b0;
    abort         = 1'b0;
    case (state)
      BUSY: begin
        mem.mem_read  = (op_q == OP_RD);
        mem.mem_write = (op_q == OP_WR);
      end
      DONE: begin
        i_ack = (win_q == REQ_I);
        d_ack = (win_q == REQ_D);
        abort = aborted_q;
      end
      default: ;
    endcase
  end

  // Stage boundary: registered request (grant in IDLE) and response capture (BUSY)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_q     <= REQ_I;
      op_q      <= OP_RD;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      wait_q    <= '0;
      aborted_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (grant_any) begin
          win_q     <= winner;
          wait_q    <= '0;
          aborted_q <= 1'b0;
          if (winner == REQ_D) begin
            addr_q  <= d_addr;
            wdata_q <= d_wdata;
            op_q    <= d_wr ? OP_WR : OP_RD;
          end else begin
            addr_q  <= i_addr;
            wdata_q <= '0;
            op_q    <= OP_RD;
          end
        end
        BUSY: begin
          if (mem.mem_ready) begin
            if (op_q == OP_RD) begin
              if (win_q == REQ_D) d_rdata_q <= mem.mem_rdata;
              else                i_rdata_q <= mem.mem_rdata;
            end
          end else if (timeout) begin
            aborted_q <= 1'b1;
            if (win_q == REQ_D) d_rdata_q <= '0;
            else                i_rdata_q <= '0;
          end else begin
            wait_q <= sat_inc(wait_q);
          end
        end
        default: ;
      endcase
    end
  end

  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign i_rdata       = i_rdata_q;
  assign d_rdata       = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests, memory model, decoupled ack monitor.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  import proc_pkg::*;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } op_t;

  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
    bit          abrt;
  } ack_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_rd, d_rd, d_wr;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_ack, d_ack, abort;
  logic [31:0] i_rdata, d_rdata;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mif ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .i_rd    (i_rd),
    .i_addr  (i_addr),
    .i_ack   (i_ack),
    .i_rdata (i_rdata),
    .d_rd    (d_rd),
    .d_wr    (d_wr),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_ack   (d_ack),
    .d_rdata (d_rdata),
    .mem     (mif),
    .abort   (abort)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  op_t  exp_ops [$];
  ack_t exp_acks[$];
  logic [31:0] mem_model [bit [31:0]];
  int   ready_delay = 2;
  logic spurious    = 1'b0;
  int   busy_cnt    = 0;
  logic [31:0] cur_addr;
  logic prev_i_ack = 1'b0, prev_d_ack = 1'b0;
  int   cyc_a, cyc_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  function automatic op_t mk_op(input bit wr, input logic [31:0] a, input logic [31:0] w);
    op_t o;
    o.wr = wr; o.addr = a; o.wdata = w;
    return o;
  endfunction

  function automatic ack_t mk_ack(input bit is_d, input logic [31:0] r, input bit ab);
    ack_t k;
    k.is_d = is_d; k.rdata = r; k.abrt = ab;
    return k;
  endfunction

  // Drives one request (side 0 = I, 1 = D) and holds it until the matching ack, bounded.
  task automatic do_req(input bit side, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] w, output int cyc);
    bit got;
    cyc = 0;
    got = 1'b0;
    if (side) begin d_addr = a; d_wdata = w; d_rd = rd; d_wr = wr; end
    else      begin i_addr = a; i_rd = 1'b1; end
    while (!got && cyc < 60) begin
      @(negedge clk);
      cyc++;
      got = side ? d_ack : i_ack;
    end
    if (!got) flag_fail(side ? "d_ack_timeout" : "i_ack_timeout");
    if (side) begin d_rd = 1'b0; d_wr = 1'b0; end
    else      i_rd = 1'b0;
  endtask

  // MainMem model: checks each new op against the scoreboard, answers after ready_delay cycles.
  initial begin
    mif.mem_ready = 1'b0;
    mif.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mif.mem_read || mif.mem_write) begin
        busy_cnt++;
        if (busy_cnt == 1) begin
          op_t e;
          cur_addr = mif.mem_addr;
          if (mif.mem_read && mif.mem_write) flag_fail("read_and_write_both_high");
          if (exp_ops.size() == 0) flag_fail("unexpected_mem_op");
          else begin
            e = exp_ops.pop_front();
            chk("mem_write", {31'd0, mif.mem_write}, {31'd0, e.wr});
            chk("mem_read", {31'd0, mif.mem_read}, {31'd0, !e.wr});
            chk("mem_addr", mif.mem_addr, e.addr);
            if (e.wr) chk("mem_wdata", mif.mem_wdata, e.wdata);
          end
          if (mif.mem_write) mem_model[mif.mem_addr] = mif.mem_wdata;
        end else begin
          chk("mem_addr_hold", mif.mem_addr, cur_addr);
        end
        if (ready_delay != 0 && busy_cnt == ready_delay) begin
          mif.mem_ready = 1'b1;
          mif.mem_rdata = mem_model.exists(mif.mem_addr) ? mem_model[mif.mem_addr] : 32'h0;
        end else begin
          mif.mem_ready = 1'b0;
        end
      end else begin
        busy_cnt      = 0;
        mif.mem_ready = spurious;
        mif.mem_rdata = 32'hFFFF_FFFF;
      end
    end
  end

  // Ack monitor: pops the expected response whenever an ack is presented.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        if (i_ack && d_ack) flag_fail("both_acks_high");
        if ((i_ack && prev_i_ack) || (d_ack && prev_d_ack)) flag_fail("ack_longer_than_one_cycle");
        if (i_ack || d_ack) begin
          if (exp_acks.size() == 0) flag_fail("unexpected_ack");
          else begin
            ack_t e;
            e = exp_acks.pop_front();
            chk("ack_side_is_d", {31'd0, d_ack}, {31'd0, e.is_d});
            chk("ack_rdata", d_ack ? d_rdata : i_rdata, e.rdata);
            chk("ack_abort", {31'd0, abort}, {31'd0, e.abrt});
          end
        end else if (abort) begin
          flag_fail("abort_without_ack");
        end
      end
      prev_i_ack = i_ack;
      prev_d_ack = d_ack;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_expired");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_model[32'h40]  = 32'hDEAD_BEEF;
    mem_model[32'h80]  = 32'h0BAD_C0DE;
    mem_model[32'h180] = 32'hCAFE_F00D;
    mem_model[32'h1C0] = 32'h1111_2222;
    mem_model[32'h300] = 32'h7777_7777;
    reset = 1'b0;
    i_rd = 0; d_rd = 0; d_wr = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0;
    repeat (3) @(negedge clk);
    chk("rst_mem_read", {31'd0, mif.mem_read}, 32'd0);
    chk("rst_mem_write", {31'd0, mif.mem_write}, 32'd0);
    chk("rst_mem_addr", mif.mem_addr, 32'd0);
    chk("rst_mem_wdata", mif.mem_wdata, 32'd0);
    chk("rst_acks_abort", {29'd0, i_ack, d_ack, abort}, 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // I read 0x40, ready in the 2nd BUSY cycle
    ready_delay = 2;
    exp_ops.push_back(mk_op(0, 32'h40, 0));
    exp_acks.push_back(mk_ack(0, 32'hDEAD_BEEF, 0));
    do_req(0, 1, 0, 32'h40, 0, cyc_a);
    chk("t1_req_to_ack_cycles", cyc_a, 3);
    @(negedge clk);

    // mem_ready while idle must not produce anything
    spurious = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("spurious_ready_no_ack", {30'd0, i_ack, d_ack}, 32'd0);
    end
    spurious = 1'b0;
    @(negedge clk);

    // D read then D write: d_rdata must survive the write
    ready_delay = 1;
    exp_ops.push_back(mk_op(0, 32'h180, 0));
    exp_acks.push_back(mk_ack(1, 32'hCAFE_F00D, 0));
    do_req(1, 1, 0, 32'h180, 0, cyc_a);
    chk("d_read_cycles", cyc_a, 2);
    @(negedge clk);
    ready_delay = 2;
    exp_ops.push_back(mk_op(1, 32'h100, 32'h1234_5678));
    exp_acks.push_back(mk_ack(1, 32'hCAFE_F00D, 0));
    do_req(1, 0, 1, 32'h100, 32'h1234_5678, cyc_a);
    chk("write_landed", mem_model[32'h100], 32'h1234_5678);
    @(negedge clk);

    // Simultaneous I and D reads; last grant was D
    ready_delay = 1;
`ifdef MEM_ARB_RR_EN
    exp_ops.push_back(mk_op(0, 32'h40, 0));
    exp_ops.push_back(mk_op(0, 32'h1C0, 0));
    exp_acks.push_back(mk_ack(0, 32'hDEAD_BEEF, 0));
    exp_acks.push_back(mk_ack(1, 32'h1111_2222, 0));
`else
    exp_ops.push_back(mk_op(0, 32'h1C0, 0));
    exp_ops.push_back(mk_op(0, 32'h40, 0));
    exp_acks.push_back(mk_ack(1, 32'h1111_2222, 0));
    exp_acks.push_back(mk_ack(0, 32'hDEAD_BEEF, 0));
`endif
    fork
      do_req(1, 1, 0, 32'h1C0, 0, cyc_a);
      do_req(0, 1, 0, 32'h40, 0, cyc_b);
    join
`ifdef MEM_ARB_RR_EN
    chk("tie_i_first_cycles", cyc_b, 2);
    chk("tie_d_second_cycles", cyc_a, 5);
`else
    chk("tie_d_first_cycles", cyc_a, 2);
    chk("tie_i_second_cycles", cyc_b, 5);
`endif
    @(negedge clk);

    // d_rd and d_wr together: write wins
    exp_ops.push_back(mk_op(1, 32'h200, 32'hA5A5_A5A5));
    exp_acks.push_back(mk_ack(1, 32'h1111_2222, 0));
    do_req(1, 1, 1, 32'h200, 32'hA5A5_A5A5, cyc_a);
    @(negedge clk);

    // No mem_ready: abort after MAX_WAIT=4 BUSY cycles
    ready_delay = 0;
    exp_ops.push_back(mk_op(0, 32'h300, 0));
    exp_acks.push_back(mk_ack(1, 32'h0, 1));
    do_req(1, 1, 0, 32'h300, 0, cyc_a);
    chk("abort_cycles", cyc_a, 5);
    @(negedge clk);
    ready_delay = 1;
    exp_ops.push_back(mk_op(0, 32'h40, 0));
    exp_acks.push_back(mk_ack(0, 32'hDEAD_BEEF, 0));
    do_req(0, 1, 0, 32'h40, 0, cyc_a);
    chk("after_abort_idle_cycles", cyc_a, 2);
    @(negedge clk);

    // Reset during BUSY abandons the op; the held request restarts afterwards
    ready_delay = 0;
    exp_ops.push_back(mk_op(0, 32'h80, 0));
    exp_ops.push_back(mk_op(0, 32'h80, 0));
    exp_acks.push_back(mk_ack(0, 32'h0BAD_C0DE, 0));
    fork
      do_req(0, 1, 0, 32'h80, 0, cyc_a);
      begin
        int w;
        w = 0;
        while (!mif.mem_read && w < 20) begin @(negedge clk); w++; end
        if (!mif.mem_read) flag_fail("reset_test_no_busy");
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_mem_read", {31'd0, mif.mem_read}, 32'd0);
        chk("rst_mid_acks", {30'd0, i_ack, d_ack}, 32'd0);
        chk("rst_mid_i_rdata", i_rdata, 32'd0);
        ready_delay = 2;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
      end
    join
    repeat (3) @(negedge clk);

    chk("ops_left", exp_ops.size(), 0);
    chk("acks_left", exp_acks.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
